// File: rtl/aer_event_fifo.sv
// AER event FIFO: buffers event words from the pixel-array AER stage and hands them to the
// readout with a first-word-fall-through valid/ready interface. Events arriving while the
// buffer is full are dropped and flagged via a sticky overflow bit.
// Optional build macro AER_FIFO_DROP_CNT_EN adds a saturating 16-bit drop counter (drop_cnt_o).
module aer_event_fifo #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AFULL_TH = 12
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       evt_valid_i,
    input  logic [DATA_W-1:0]          evt_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       almost_full_o,
    output logic                       overflow_o,
    input  logic                       clear_ovf_i
`ifdef AER_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]                drop_cnt_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Storage is intentionally not reset; out_data_o is only meaningful when out_valid_o=1.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Pointers carry an extra MSB wrap bit to tell full from empty.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;

    logic empty;
    logic full_now;
    logic push;
    logic pop;
    logic drop;

    // Handshake decode from current pointers; a pop frees a slot for a same-cycle push.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full_now = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop      = !empty && out_ready_i;
        push     = evt_valid_i && (!full_now || pop);
        drop     = evt_valid_i && full_now && !pop;
    end

    // Next-state pointers, occupancy flags and sticky overflow (drop beats clear).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        level_d = wr_ptr_d - rd_ptr_d;
        full_d  = (level_d == PW'(DEPTH));
        afull_d = (level_d >= PW'(AFULL_TH));
        ovf_d   = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    // Event storage write on accepted push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= evt_data_i;
        end
    end

    // Output drive: head entry read combinationally (no bypass when empty).
    always_comb begin
        out_valid_o   = !empty;
        out_data_o    = mem_q[rd_ptr_q[AW-1:0]];
        level_o       = level_q;
        full_o        = full_q;
        almost_full_o = afull_q;
        overflow_o    = ovf_q;
    end

`ifdef AER_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop count; a drop coinciding with a clear leaves a count of one.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_ovf_i) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_aer_event_fifo.sv
// Directed self-checking bench for aer_event_fifo (DATA_W=32, DEPTH=16, AFULL_TH=12).
module tb_aer_event_fifo;

    logic        clk_i;
    logic        reset_i;
    logic        evt_valid_i;
    logic [31:0] evt_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [4:0]  level_o;
    logic        full_o;
    logic        almost_full_o;
    logic        overflow_o;
    logic        clear_ovf_i;
`ifdef AER_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    aer_event_fifo #(
        .DATA_W  (32),
        .DEPTH   (16),
        .AFULL_TH(12)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .evt_valid_i  (evt_valid_i),
        .evt_data_i   (evt_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .level_o      (level_o),
        .full_o       (full_o),
        .almost_full_o(almost_full_o),
        .overflow_o   (overflow_o),
        .clear_ovf_i  (clear_ovf_i)
`ifdef AER_FIFO_DROP_CNT_EN
        ,
        .drop_cnt_o   (drop_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i     = 1'b1;
        evt_valid_i = 1'b0;
        evt_data_i  = '0;
        out_ready_i = 1'b0;
        clear_ovf_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;

        // Reset state
        check("rst_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_level", {27'd0, level_o}, 32'd0);
        check("rst_full", {31'd0, full_o}, 32'd0);
        check("rst_afull", {31'd0, almost_full_o}, 32'd0);
        check("rst_ovf", {31'd0, overflow_o}, 32'd0);
        tick();

        // Single push then pop
        evt_valid_i = 1'b1;
        evt_data_i  = 32'hA5A5_0001;
        tick();
        evt_valid_i = 1'b0;
        check("t1_valid", {31'd0, out_valid_o}, 32'd1);
        check("t1_data", out_data_o, 32'hA5A5_0001);
        check("t1_level", {27'd0, level_o}, 32'd1);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("t1_valid_after_pop", {31'd0, out_valid_o}, 32'd0);
        check("t1_level_after_pop", {27'd0, level_o}, 32'd0);

        // Fill with 0..15, watching the thresholds
        for (int i = 0; i < 16; i++) begin
            evt_valid_i = 1'b1;
            evt_data_i  = i;
            tick();
            check("fill_level", {27'd0, level_o}, i + 1);
            check("fill_afull", {31'd0, almost_full_o}, (i + 1 >= 12) ? 32'd1 : 32'd0);
            check("fill_full", {31'd0, full_o}, (i + 1 == 16) ? 32'd1 : 32'd0);
        end
        evt_valid_i = 1'b0;
        check("fill_head", out_data_o, 32'd0);

        // Drop while full
        evt_valid_i = 1'b1;
        evt_data_i  = 32'h0000_DEAD;
        tick();
        evt_valid_i = 1'b0;
        check("drop_level", {27'd0, level_o}, 32'd16);
        check("drop_ovf", {31'd0, overflow_o}, 32'd1);
        check("drop_head", out_data_o, 32'd0);
`ifdef AER_FIFO_DROP_CNT_EN
        check("drop_cnt", {16'd0, drop_cnt_o}, 32'd1);
`endif

        // Push and pop together while full: no drop
        evt_valid_i = 1'b1;
        evt_data_i  = 32'h0000_BEEF;
        out_ready_i = 1'b1;
        tick();
        evt_valid_i = 1'b0;
        out_ready_i = 1'b0;
        check("pp_level", {27'd0, level_o}, 32'd16);
        check("pp_full", {31'd0, full_o}, 32'd1);
        check("pp_head", out_data_o, 32'd1);
`ifdef AER_FIFO_DROP_CNT_EN
        check("pp_cnt", {16'd0, drop_cnt_o}, 32'd1);
`endif

        // Drain: 1..15 then 0xBEEF
        out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", {31'd0, out_valid_o}, 32'd1);
            check("drain_data", out_data_o, (i < 15) ? (i + 1) : 32'h0000_BEEF);
            tick();
            check("drain_level", {27'd0, level_o}, 15 - i);
        end
        out_ready_i = 1'b0;
        check("drain_empty", {31'd0, out_valid_o}, 32'd0);
        check("drain_afull", {31'd0, almost_full_o}, 32'd0);
        check("drain_ovf_sticky", {31'd0, overflow_o}, 32'd1);

        // Refill, then drop coinciding with clear
        for (int i = 0; i < 16; i++) begin
            evt_valid_i = 1'b1;
            evt_data_i  = 32'h100 + i;
            tick();
        end
        check("refill_full", {31'd0, full_o}, 32'd1);
        evt_valid_i = 1'b1;
        evt_data_i  = 32'h0000_0BAD;
        clear_ovf_i = 1'b1;
        tick();
        evt_valid_i = 1'b0;
        check("clr_drop_ovf", {31'd0, overflow_o}, 32'd1);
        check("clr_drop_level", {27'd0, level_o}, 32'd16);
`ifdef AER_FIFO_DROP_CNT_EN
        check("clr_drop_cnt", {16'd0, drop_cnt_o}, 32'd1);
`endif
        tick();
        clear_ovf_i = 1'b0;
        check("clr_ovf", {31'd0, overflow_o}, 32'd0);
`ifdef AER_FIFO_DROP_CNT_EN
        check("clr_cnt", {16'd0, drop_cnt_o}, 32'd0);
`endif
        check("clr_head", out_data_o, 32'h100);

        // Drain 11 to reach level 5
        out_ready_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
        end
        out_ready_i = 1'b0;
        check("l5_level", {27'd0, level_o}, 32'd5);
        check("l5_afull", {31'd0, almost_full_o}, 32'd0);
        check("l5_head", out_data_o, 32'h10B);

        // Asynchronous reset mid-cycle
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid_o}, 32'd0);
        check("arst_level", {27'd0, level_o}, 32'd0);
        tick();
        reset_i = 1'b0;
        evt_valid_i = 1'b1;
        evt_data_i  = 32'h0000_1234;
        tick();
        evt_data_i  = 32'h0000_5678;
        tick();
        evt_valid_i = 1'b0;
        check("post_rst_level", {27'd0, level_o}, 32'd2);
        check("post_rst_head", out_data_o, 32'h0000_1234);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("post_rst_second", out_data_o, 32'h0000_5678);
        check("post_rst_level2", {27'd0, level_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
